// File: rtl/rr_arb_np.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_np
// Brief    : Round-robin arbiter feeding a one-entry valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_np #(
  parameter int N = 4,
  parameter int D = 16,
  localparam int c_SRC_W = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N-1:0]       i_req,
  input  logic [D-1:0]       i_data [N-1:0],
  output logic [N-1:0]       o_ack,
  output logic               o_valid,
  output logic [D-1:0]       o_data,
  output logic [c_SRC_W-1:0] o_src,
  input  logic               i_ready
);

  localparam logic [N-1:0]       c_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [c_SRC_W-1:0] c_LAST = c_SRC_W'(N - 1);

  logic [c_SRC_W-1:0] r_ptr;
  logic [c_SRC_W-1:0] w_grant;
  logic [c_SRC_W-1:0] w_k;
  logic               w_found;
  logic               w_load;
  int                 w_idx;

  // Scan from the pointer upward with wraparound; the first active request wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      w_k = w_idx[c_SRC_W-1:0];
      if (!w_found && i_req[w_k]) begin
        w_found = 1'b1;
        w_grant = w_k;
      end
    end
  end

  assign w_load = (!o_valid || i_ready) && (|i_req) && !i_rst;
  assign o_ack  = w_load ? (c_ONE << w_grant) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_src   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data[w_grant];
      o_src   <= w_grant;
      r_ptr   <= (w_grant == c_LAST) ? '0 : w_grant + 1'b1;
    end else if (o_valid && i_ready) begin
      // Consumer took the word and nothing is waiting to replace it.
      o_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_np.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_np
// Brief    : Self-checking bench for rr_arb_np (N=4 randomized, N=3 directed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_np;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, ready4, valid4;
  logic [3:0]  req4, ack4;
  logic [15:0] data4 [3:0];
  logic [15:0] odata4;
  logic [1:0]  src4;

  logic        rst3, ready3, valid3;
  logic [2:0]  req3, ack3;
  logic [15:0] data3 [2:0];
  logic [15:0] odata3;
  logic [1:0]  src3;

  rr_arb_np #(.N(4), .D(16)) u_dut4 (
    .i_clk(clk), .i_rst(rst4), .i_req(req4), .i_data(data4), .o_ack(ack4),
    .o_valid(valid4), .o_data(odata4), .o_src(src4), .i_ready(ready4)
  );

  rr_arb_np #(.N(3), .D(16)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_req(req3), .i_data(data3), .o_ack(ack3),
    .o_valid(valid3), .o_data(odata3), .o_src(src3), .i_ready(ready3)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model of the N=4 instance: rotating priority pointer plus output register.
  bit          m_valid = 1'b0;
  logic [15:0] m_data  = '0;
  int          m_src   = 0;
  int          m_ptr   = 0;

  function automatic int model_grant();
    for (int i = 0; i < 4; i++) begin
      if (req4[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ack();
    int g;
    g = model_grant();
    if (rst4 || g < 0 || (m_valid && !ready4)) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic model_tick();
    int g;
    g = model_grant();
    if (rst4) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if ((!m_valid || ready4) && g >= 0) begin
      m_valid = 1'b1; m_data = data4[g]; m_src = g; m_ptr = (g + 1) % 4;
    end else if (m_valid && ready4) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst4 = 1'b1; ready4 = 1'b1; req4 = 4'($urandom_range(1, 15));
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (ack4 !== 4'b0000) begin
        failures++; $display("FAIL reset_ack got=%b want=0000", ack4);
      end
      tick();
    end
    rst4 = 1'b0; req4 = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (valid4 !== 1'b0 || odata4 !== 16'h0 || src4 !== 2'd0 || ack4 !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle got v=%b d=%h s=%0d a=%b want v=0 d=0000 s=0 a=0000",
                 valid4, odata4, src4, ack4);
      end
      tick();
    end
  endtask

  task automatic test_single();
    req4 = 4'b0100; data4[2] = 16'hBEEF; ready4 = 1'b1;
    #1;
    checks++;
    if (ack4 !== 4'b0100) begin
      failures++; $display("FAIL single_ack got=%b want=0100", ack4);
    end
    tick();
    req4 = 4'b0000;
    #1;
    checks++;
    if (valid4 !== 1'b1 || odata4 !== 16'hBEEF || src4 !== 2'd2) begin
      failures++;
      $display("FAIL single_out got v=%b d=%h s=%0d want v=1 d=beef s=2", valid4, odata4, src4);
    end
  endtask

  task automatic test_fairness();
    rst4 = 1'b1; tick(); rst4 = 1'b0;
    req4 = 4'b1111; ready4 = 1'b1;
    for (int k = 0; k < 4; k++) data4[k] = 16'(k + 16'h10);
    for (int c = 0; c <= 8; c++) begin
      #1;
      if (c < 8) begin
        checks++;
        if (ack4 !== 4'(1 << (c % 4))) begin
          failures++; $display("FAIL fair_ack cycle=%0d got=%b want=%b", c, ack4, 4'(1 << (c % 4)));
        end
      end
      if (c > 0) begin
        checks++;
        if (valid4 !== 1'b1 || src4 !== 2'((c - 1) % 4) || odata4 !== 16'((c - 1) % 4 + 16'h10)) begin
          failures++;
          $display("FAIL fair_out cycle=%0d got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                   c, valid4, src4, odata4, (c - 1) % 4, 16'((c - 1) % 4 + 16'h10));
        end
      end
      if (c < 8) tick();
    end
  endtask

  task automatic test_backpressure();
    rst4 = 1'b1; tick(); rst4 = 1'b0;
    req4 = 4'b0001; data4[0] = 16'h0011; data4[1] = 16'h2222; ready4 = 1'b1;
    tick();
    req4 = 4'b0010; ready4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ack4 !== 4'b0000 || valid4 !== 1'b1 || odata4 !== 16'h0011 || src4 !== 2'd0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got a=%b v=%b d=%h s=%0d want a=0000 v=1 d=0011 s=0",
                 c, ack4, valid4, odata4, src4);
      end
      tick();
    end
    ready4 = 1'b1;
    #1;
    checks++;
    if (ack4 !== 4'b0010) begin
      failures++; $display("FAIL bp_release_ack got=%b want=0010", ack4);
    end
    tick();
    req4 = 4'b0000;
    #1;
    checks++;
    if (valid4 !== 1'b1 || src4 !== 2'd1 || odata4 !== 16'h2222) begin
      failures++;
      $display("FAIL bp_release_out got v=%b s=%0d d=%h want v=1 s=1 d=2222", valid4, src4, odata4);
    end
  endtask

  task automatic test_drain();
    req4 = 4'b0000; ready4 = 1'b1;
    #1;
    checks++;
    if (ack4 !== 4'b0000) begin
      failures++; $display("FAIL drain_ack got=%b want=0000", ack4);
    end
    tick();
    #1;
    checks++;
    if (valid4 !== 1'b0 || odata4 !== 16'h2222 || src4 !== 2'd1) begin
      failures++;
      $display("FAIL drain_out got v=%b d=%h s=%0d want v=0 d=2222 s=1", valid4, odata4, src4);
    end
  endtask

  task automatic test_random();
    bit          pend  [4];
    logic [15:0] pdata [4];
    logic [3:0]  exp_ack;
    int          g;
    for (int k = 0; k < 4; k++) pend[k] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst4 = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k]  = 1'b1;
          pdata[k] = 16'($urandom);
        end
        req4[k]  = pend[k];
        data4[k] = pend[k] ? pdata[k] : 16'($urandom);
      end
      ready4 = ($urandom_range(0, 3) != 0);
      #1;
      exp_ack = model_ack();
      g = model_grant();
      checks++;
      if (ack4 !== exp_ack) begin
        failures++; $display("FAIL rand_ack cycle=%0d got=%b want=%b", c, ack4, exp_ack);
      end
      checks++;
      if (valid4 !== m_valid || (m_valid && (odata4 !== m_data || src4 !== 2'(m_src)))) begin
        failures++;
        $display("FAIL rand_out cycle=%0d got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                 c, valid4, odata4, src4, m_valid, m_data, m_src);
      end
      tick();
      if (exp_ack != 4'b0000) pend[g] = 1'b0;
    end
    rst4 = 1'b0; req4 = 4'b0000;
  endtask

  task automatic test_npot_reset();
    rst3 = 1'b1; tick(); rst3 = 1'b0;
    req3 = 3'b111; ready3 = 1'b1;
    for (int k = 0; k < 3; k++) data3[k] = 16'(16'hA0 + k);
    for (int c = 0; c <= 4; c++) begin
      #1;
      if (c < 4) begin
        checks++;
        if (ack3 !== 3'(1 << (c % 3))) begin
          failures++; $display("FAIL npot_ack cycle=%0d got=%b want=%b", c, ack3, 3'(1 << (c % 3)));
        end
      end
      if (c > 0) begin
        checks++;
        if (valid3 !== 1'b1 || src3 !== 2'((c - 1) % 3) || odata3 !== 16'(16'hA0 + (c - 1) % 3)) begin
          failures++;
          $display("FAIL npot_out cycle=%0d got v=%b s=%0d d=%h want v=1 s=%0d",
                   c, valid3, src3, odata3, (c - 1) % 3);
        end
      end
      if (c < 4) tick();
    end
    rst3 = 1'b1;
    #1;
    checks++;
    if (ack3 !== 3'b000) begin
      failures++; $display("FAIL npot_rst_ack got=%b want=000", ack3);
    end
    tick();
    rst3 = 1'b0;
    #1;
    checks++;
    if (valid3 !== 1'b0 || ack3 !== 3'b001) begin
      failures++; $display("FAIL npot_after_rst got v=%b a=%b want v=0 a=001", valid3, ack3);
    end
    tick();
    #1;
    checks++;
    if (valid3 !== 1'b1 || src3 !== 2'd0 || odata3 !== 16'hA0) begin
      failures++;
      $display("FAIL npot_first got v=%b s=%0d d=%h want v=1 s=0 d=00a0", valid3, src3, odata3);
    end
  endtask

  initial begin
    rst4 = 1'b1; ready4 = 1'b0; req4 = '0;
    rst3 = 1'b1; ready3 = 1'b0; req3 = '0;
    for (int k = 0; k < 4; k++) data4[k] = '0;
    for (int k = 0; k < 3; k++) data3[k] = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_drain();
    test_random();
    test_npot_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arb_np.md
# rr_arb_np

Round-robin arbiter that shares one D-bit output channel between N requesters. Each cycle it selects one active requester with rotating priority, acknowledges it, and captures its word into a one-entry output register with a valid/ready handshake. It sits in front of the shared N-input mux datapath: its grant index drives the mux select, and its registered output feeds a single downstream consumer such as a memory write port or register-file port.

## Interface

Parameters:
- N, default 4: number of requesters; legal range N >= 2, not required to be a power of two.
- D, default 16: bit width of each requester word and of the output.

Ports:
- i_clk, input, 1: the single clock; all state updates on its rising edge.
- i_rst, input, 1: reset, synchronous and active-high.
- i_req, input, N: per-requester request; bit k high means i_data[k] holds a word to transfer.
- i_data, input, D x N (unpacked array [N-1:0] of [D-1:0]): per-requester data words.
- o_ack, output, N: one-hot grant; bit k high means i_data[k] is captured at the next rising edge.
- o_valid, output, 1: the output register holds a word.
- o_data, output, D: the captured word.
- o_src, output, $clog2(N): index of the requester whose word is in o_data.
- i_ready, input, 1: the consumer accepts o_data at the next rising edge while o_valid is high.

## Operation

- The block has two states, encoded by o_valid:
  - EMPTY: o_valid = 0.
  - FULL: o_valid = 1.
- Load condition: load = (!o_valid || i_ready) && (|i_req) && !i_rst.
- Grant selection: g is the first index k with i_req[k] = 1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- o_ack is combinational. o_ack = onehot(g) when load is true; otherwise o_ack = 0.
- On a rising edge where load is true:
  - o_data <= i_data[g], o_src <= g, o_valid <= 1.
  - ptr <= g+1, wrapping to 0 when g = N-1.
- On a rising edge where o_valid && i_ready && !(|i_req): o_valid <= 0. o_data and o_src hold their last values.
- FULL with i_ready = 0: o_data, o_src and ptr hold, and o_ack = 0. Requesters stay pending; i_req and i_data must remain stable until acked.
- ptr changes only on a load. A requester that is not acked keeps its priority position.
- The mux select presented to the shared datapath is g. It is meaningful only while o_ack is nonzero.

## Timing

- Reset: on a rising edge with i_rst = 1, o_valid <= 0, o_data <= 0, o_src <= 0, ptr <= 0. o_ack = 0 throughout any cycle with i_rst = 1.
- Latency: a request that is acked in cycle t appears on o_data/o_valid in cycle t+1.
- Throughput: one word per cycle while i_ready stays high and requests are continuous. This applies in FULL when i_ready = 1 and i_req != 0: the consumer takes the old word and the new word loads on the same edge.
- i_ready is ignored while o_valid = 0.
- Reset mid-transfer: the held word is discarded, no ack is issued in the reset cycle, and ptr returns to 0.
- Non-power-of-two N: o_src never exceeds N-1, and ptr wraps from N-1 to 0.
- Simultaneous requests with i_req = all ones and i_ready tied high: grants rotate 0, 1, ..., N-1, 0, ... with no requester skipped.

## Test plan

- Reset then idle: i_rst high for 2 cycles, then i_req = 0 -> o_valid = 0, o_data = 0, o_src = 0, o_ack = 0 on every cycle.
- Single requester, N=4, D=16: i_req = 4'b0100, i_data[2] = 16'hBEEF, i_ready = 1 -> o_ack = 4'b0100 in cycle t; o_valid = 1, o_data = 16'hBEEF, o_src = 2 in cycle t+1.
- Fairness: i_req = 4'b1111, i_data[k] = k+16'h10, i_ready = 1 for 8 cycles -> o_src sequence 0, 1, 2, 3, 0, 1, 2, 3, with o_data matching each o_src.
- Backpressure: FULL with o_data = 16'h0011, i_ready = 0 for 3 cycles, i_req = 4'b0010 -> o_ack = 0 and o_data stable for those 3 cycles; i_ready = 1 in the fourth cycle -> o_ack = 4'b0010 that cycle, next o_src = 1.
- Drain: FULL, i_ready = 1, i_req = 0 -> o_valid = 0 next cycle, o_data unchanged.
- Non-power-of-two and reset mid-operation: N = 3, i_req = 3'b111 -> o_src sequence 0, 1, 2, 0. Asserting i_rst while FULL -> o_valid = 0 and o_ack = 0 in that cycle; the first grant after reset is index 0.
